// File: rtl/block_pkg.sv
// Shared definitions for the block collision checker.
//   BoardWDefault / BoardHDefault : default playfield size (cells x rows)
//   MatrixW                       : width of the packed 4x4 shape matrix
//   state_e                       : scan FSM states
//   row_nibble()                  : extracts row r of a shape, column 0 in bit 3
package block_pkg;

  localparam int unsigned BoardWDefault = 10;
  localparam int unsigned BoardHDefault = 20;
  localparam int unsigned MatrixW       = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  // Row r occupies bits 15-4r down to 12-4r; cell (r,0) lands in bit 3.
  function automatic logic [3:0] row_nibble(input logic [MatrixW-1:0] m, input logic [1:0] r);
    logic [MatrixW-1:0] shifted;
    shifted = m << {r, 2'b00};
    return shifted[MatrixW-1 -: 4];
  endfunction

endpackage

// File: rtl/block_row_mask.sv
// Maps one shape row onto the board columns.
//   nibble : shape row, bit 3 = matrix column 0
//   pos_x  : board column of matrix column 0
//   mask   : BOARD_W-bit mask of occupied in-bounds board columns
//   oob    : a set cell falls at or beyond column BOARD_W
// Purely combinational.
module block_row_mask #(
  parameter int unsigned BOARD_W = block_pkg::BoardWDefault
) (
  input  logic [3:0]         nibble,
  input  logic [3:0]         pos_x,
  output logic [BOARD_W-1:0] mask,
  output logic               oob
);

  always_comb begin
    logic [4:0] col;
    mask = '0;
    oob  = 1'b0;
    col  = '0;
    for (int c = 0; c < 4; c++) begin
      if (nibble[3-c]) begin
        // 5-bit sum so pos_x = 15 plus offset 3 cannot wrap back on-board.
        col = {1'b0, pos_x} + 5'(c);
        if (32'(col) >= BOARD_W) begin
          oob = 1'b1;
        end else begin
          for (int unsigned j = 0; j < BOARD_W; j++) begin
            if (32'(col) == j) mask[j] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/block_collide.sv
// Checks whether a 4x4 shape placed at (pos_x, pos_y) collides with the board
// edges or with occupied cells, reading the board one row at a time.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : request to check one placement (accepted only when idle)
//   block_matrix       : 4x4 shape, cell (r,c) = bit 15-(4r+c)
//   pos_x, pos_y       : board position of matrix cell (0,0)
//   rd_en, rd_row      : board row read request
//   rd_data            : occupied bits of the requested row, one cycle after rd_en
//   busy, done, hit    : scan in progress, one-cycle completion pulse, result
// Build option: define COLLIDE_EARLY_EXIT_EN to skip empty rows in one cycle and
// to finish right after the first collision; otherwise latency is fixed.
module block_collide
  import block_pkg::*;
#(
  parameter int unsigned BOARD_W = BoardWDefault,
  parameter int unsigned BOARD_H = BoardHDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MatrixW-1:0] block_matrix,
  input  logic [3:0]         pos_x,
  input  logic [4:0]         pos_y,
  output logic               rd_en,
  output logic [4:0]         rd_row,
  input  logic [BOARD_W-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic               hit
);

`ifdef COLLIDE_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  state_e             state_q;
  logic [MatrixW-1:0] matrix_q;
  logic [3:0]         pos_x_q;
  logic [4:0]         pos_y_q;
  logic [1:0]         row_q;
  logic               read_q;
  logic               hit_q;
  logic               busy_q;
  logic               done_q;

  logic [3:0]         nibble;
  logic               row_empty;
  logic [5:0]         y_sum;
  logic               y_oob;
  logic               x_oob;
  logic               row_oob;
  logic [BOARD_W-1:0] row_mask;
  logic               issue_read;
  logic               wait_hit;

  assign nibble    = row_nibble(matrix_q, row_q);
  assign row_empty = (nibble == 4'b0000);
  // 6-bit sum so pos_y = 31 plus row 3 is still seen as off-board.
  assign y_sum     = {1'b0, pos_y_q} + {4'b0000, row_q};
  assign y_oob     = (32'(y_sum) >= BOARD_H);
  assign row_oob   = x_oob | y_oob;

  block_row_mask #(
    .BOARD_W (BOARD_W)
  ) u_row_mask (
    .nibble (nibble),
    .pos_x  (pos_x_q),
    .mask   (row_mask),
    .oob    (x_oob)
  );

  assign issue_read = (state_q == StIssue) && !row_empty && !row_oob;
  // read_q gates rd_data so WAIT cycles without a read never flag a hit.
  assign wait_hit   = read_q && |(row_mask & rd_data);

  assign rd_en  = issue_read;
  assign rd_row = issue_read ? y_sum[4:0] : 5'd0;
  assign busy   = busy_q;
  assign done   = done_q;
  assign hit    = hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      matrix_q <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      row_q    <= '0;
      read_q   <= 1'b0;
      hit_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            matrix_q <= block_matrix;
            pos_x_q  <= pos_x;
            pos_y_q  <= pos_y;
            row_q    <= 2'd0;
            read_q   <= 1'b0;
            hit_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          read_q <= issue_read;
          if (!row_empty && row_oob) hit_q <= 1'b1;
          if (EarlyExit && !row_empty && row_oob) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (EarlyExit && row_empty) begin
            if (row_q == 2'd3) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              row_q <= row_q + 2'd1;
            end
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (wait_hit) hit_q <= 1'b1;
          if ((row_q == 2'd3) || (EarlyExit && wait_hit)) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            row_q   <= row_q + 2'd1;
            state_q <= StIssue;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_block_collide.sv
// Self-checking bench for block_collide: directed table, hand-written
// start-while-busy and reset-mid-scan sequences, and randomized placements
// checked against a cell-level reference model.
module tb_block_collide;
  import block_pkg::*;

  localparam int W = BoardWDefault;
  localparam int H = BoardHDefault;

`ifdef COLLIDE_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  block_matrix = '0;
  logic [3:0]   pos_x = '0;
  logic [4:0]   pos_y = '0;
  logic         rd_en;
  logic [4:0]   rd_row;
  logic [W-1:0] rd_data = '0;
  logic         busy;
  logic         done;
  logic         hit;

  block_collide dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .block_matrix (block_matrix),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .rd_en        (rd_en),
    .rd_row       (rd_row),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .hit          (hit)
  );

  always #5 clk = ~clk;

  // Board memory: data follows rd_en by one cycle; junk otherwise.
  logic [W-1:0] board [32];
  always @(posedge clk) rd_data <= rd_en ? board[rd_row] : W'($urandom);

  int log_q[$];
  always @(negedge clk) if (rd_en === 1'b1) log_q.push_back(int'(rd_row));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: walk the 16 cells directly against board and edges.
  bit m_hit;
  int m_lat;
  int m_reads[$];

  function automatic void model(input logic [15:0] m, input int x, input int y);
    m_hit = 1'b0;
    m_lat = 0;
    m_reads.delete();
    for (int r = 0; r < 4; r++) begin
      bit any = 1'b0;
      bit oob = 1'b0;
      bit rh  = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (m[15-(4*r+c)]) begin
          any = 1'b1;
          if (x + c >= W || y + r >= H) oob = 1'b1;
          else if (board[y+r][x+c]) rh = 1'b1;
        end
      end
      if (!any) begin
        m_lat += Early ? 1 : 2;
        continue;
      end
      if (oob) begin
        m_hit = 1'b1;
        m_lat += Early ? 1 : 2;
        if (Early) break;
        continue;
      end
      m_reads.push_back(y + r);
      m_lat += 2;
      if (rh) begin
        m_hit = 1'b1;
        if (Early) break;
      end
    end
    m_lat += 1;  // DONE cycle
  endfunction

  // Call at a negedge. Start is sampled at the next posedge (T0).
  task automatic run(input string name, input logic [15:0] m, input int x, input int y,
                     input bit exp_hit, input int exp_lat, input bit poke);
    int lat;
    int extra;
    model(m, x, y);
    log_q.delete();
    block_matrix = m;
    pos_x        = 4'(x);
    pos_y        = 5'(y);
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    block_matrix = 16'($urandom);
    pos_x        = 4'($urandom);
    pos_y        = 5'($urandom);
    check({name, " busy_after_start"}, int'(busy), 1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (poke && k == 3) begin
        start        = 1'b1;
        block_matrix = 16'($urandom);
        pos_x        = 4'($urandom);
        pos_y        = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, " done_cycle"}, lat, exp_lat);
    check({name, " hit"}, int'(hit), int'(exp_hit));
    check({name, " read_count"}, log_q.size(), m_reads.size());
    for (int i = 0; i < log_q.size() && i < m_reads.size(); i++)
      check($sformatf("%s read%0d_row", name, i), log_q[i], m_reads[i]);
    @(negedge clk);
    check({name, " busy_after_done"}, int'(busy), 0);
    check({name, " hit_held"}, int'(hit), int'(exp_hit));
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1) extra++;
      @(negedge clk);
    end
    check({name, " extra_done"}, extra, 0);
  endtask

  typedef struct {
    logic [15:0] m;
    int          x;
    int          y;
    bit          hit;
    int          lat_base;
    int          lat_early;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n_done;
    // Placement, expected hit, done cycle without / with early exit.
    tbl[0] = '{16'h4444, 0, 0,  1'b0, 9, 9};
    tbl[1] = '{16'h4444, 3, 17, 1'b1, 9, 8};
    tbl[2] = '{16'h0660, 8, 0,  1'b1, 9, 3};
    tbl[3] = '{16'h0660, 1, 4,  1'b1, 9, 4};
    tbl[4] = '{16'h8000, 9, 19, 1'b1, 9, 3};
    tbl[5] = '{16'h1000, 9, 0,  1'b1, 9, 2};
    tbl[6] = '{16'h0000, 0, 0,  1'b0, 9, 5};
    tbl[7] = '{16'h000F, 0, 16, 1'b0, 9, 6};
    tbl[8] = '{16'h0001, 15, 31, 1'b1, 9, 5};

    for (int i = 0; i < 32; i++) board[i] = '0;
    board[5]  = W'(10'b0000000100);
    board[19] = W'(10'b1000000000);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset hit", int'(hit), 0);
    check("reset rd_en", int'(rd_en), 0);
    check("reset rd_row", int'(rd_row), 0);
    rst_n = 1'b1;

    // Directed table; first start lands on the first clock after reset release.
    for (int i = 0; i < 9; i++) begin
      run($sformatf("vec%0d", i), tbl[i].m, tbl[i].x, tbl[i].y, tbl[i].hit,
          Early ? tbl[i].lat_early : tbl[i].lat_base, 1'b0);
    end

    // Start re-asserted while busy with different inputs: ignored.
    run("poke", tbl[3].m, tbl[3].x, tbl[3].y, tbl[3].hit,
        Early ? tbl[3].lat_early : tbl[3].lat_base, 1'b1);

    // Reset during WAIT of row 2 (cycle T0+6).
    log_q.delete();
    block_matrix = Early ? 16'h4444 : 16'hF000;
    pos_x        = 4'd0;
    pos_y        = Early ? 5'd0 : 5'd5;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 6; k++) @(negedge clk);
    if (!Early) check("rst_mid hit_before", int'(hit), 1);
    check("rst_mid busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", int'(busy), 0);
    check("rst_mid hit", int'(hit), 0);
    check("rst_mid done", int'(done), 0);
    check("rst_mid rd_en", int'(rd_en), 0);
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("rst_mid no_done", n_done, 0);
    rst_n = 1'b1;
    run("after_rst", tbl[0].m, tbl[0].x, tbl[0].y, tbl[0].hit,
        Early ? tbl[0].lat_early : tbl[0].lat_base, 1'b0);

    // Randomized placements on random sparse boards.
    for (int t = 0; t < 40; t++) begin
      logic [15:0] m;
      int          x;
      int          y;
      for (int i = 0; i < 32; i++) board[i] = (i < H) ? W'($urandom & $urandom & $urandom) : '0;
      m = 16'($urandom);
      x = $urandom_range(0, 15);
      y = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 18);
      model(m, x, y);
      run($sformatf("rand%0d", t), m, x, y, m_hit, m_lat, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
